window_3x3_gen: RTL and testbench
=================================

Name: window_3x3_gen

Overview:
Streaming 3x3 neighbourhood generator. It sits directly upstream of the gray-scale 3x3 gradient and median stages. It accepts one 8-bit gray pixel per valid cycle in raster order, buffers two previous lines and emits a registered 3x3 window (s0..s8) for every interior centre pixel. There is no backpressure; downstream stages are combinational on the window.

Parameters:
IMG_W, 640, pixels per line (>=3)
IMG_H, 480, lines per frame (>=3)
DW, 8, pixel width in bits
Derived localparams: CW=$clog2(IMG_W), RW=$clog2(IMG_H)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  pixel qualifier; gaps of any length allowed
in_sof  in  1  start of frame; meaningful only with in_valid; marks pixel (0,0)
in_data  in  DW  gray pixel
out_valid  out  1  window qualifier, single-cycle pulse per window
win  out  9*DW  window; s0 at [DW-1:0] ... s8 at [9*DW-1:8*DW]; s0 s1 s2 = top row, left to right; s4 = centre; s6 s7 s8 = bottom row
busy  out  1  high while state != IDLE

Behaviour:
- Reset (async assert, sync release): out_valid=0, win=0, busy=0, col=0, row=0, state=IDLE. Line-buffer contents are not reset and never appear in a valid window.
- Line buffers: LB0 holds row r-1, LB1 holds row r-2, each IMG_W deep. Read at address col is combinational. On an accepted pixel, LB1[col]<=LB0[col] and LB0[col]<=in_data, read-before-write.
- Window shift (accepted pixel only): each row register shifts left one column and the new right column loads {LB1[col], LB0[col], in_data} as {top, mid, bottom}.
- Output for accepted pixel (r,c): window centre is (r-1,c-1), s0=(r-2,c-2), s8=(r,c). out_valid=1 on the next cycle iff r>=2 and c>=2. Latency is 1 clk. Output count is (IMG_W-2)*(IMG_H-2) per frame.
- out_valid is 0 on any cycle without an accepted pixel on the previous edge. win holds its last value.
- Counters: col increments per accepted pixel and wraps IMG_W-1 -> 0, with row++ on wrap. Pixel (IMG_H-1, IMG_W-1) returns to IDLE with col=row=0.
- FSM:
  - IDLE: pixels without in_sof are dropped, with no counter or buffer update. in_valid&in_sof accepts the pixel as (0,0) and goes to FILL.
  - FILL: rows 0..1. Accept pixels, no output. Go to RUN when the row counter reaches 2.
  - RUN: rows 2..IMG_H-1. Accept pixels and output as above. Go to IDLE after the last pixel.
- in_sof while in FILL or RUN aborts the frame: the pixel is accepted as (0,0), state goes to FILL, and no window is emitted for it.
- Window and line-buffer contents straddling an abort are stale. They are gated by the r>=2 and c>=2 rule, which uses the new counters.
- The column wrap edge never produces a window mixing lines: c>=2 gating excludes the first two columns of each row.

Optional Feature:
Macro WIN3_FRAME_FLAGS_EN.
- Defined: adds output ports out_sof (1 bit) and out_eol (1 bit), registered alongside out_valid.
  - out_sof=1 with the first window of a frame (centre (1,1)).
  - out_eol=1 with the last window of each row (centre col IMG_W-2).
  - Both are 0 whenever out_valid=0 and both reset to 0.
- Undefined: the ports do not exist and the logic is absent. All other behaviour is identical.

Decomposition:
- Shared package img_pkg: DW default, window packing index constants (S0_LSB..S8_LSB), FSM state enum {IDLE, FILL, RUN}.
- One sub-module, line_buf_1p: single-port IMG_W x DW array with combinational read and synchronous write on we. It is instantiated twice (LB0, LB1).
- Counters, FSM and window registers stay in window_3x3_gen.

Test Plan:
1. IMG_W=4, IMG_H=4, pixel=16*r+c, continuous valid from sof -> exactly 4 out_valid pulses. The first is 1 clk after pixel (2,2) with s0=0x00, s4=0x11, s8=0x22. The last has s0=0x11, s8=0x33.
2. Same frame with random 0-3 cycle gaps in in_valid -> the same 4 windows in the same order, each 1 clk after its trigger pixel, with out_valid low in gap cycles.
3. 5 pixels without sof, then a frame -> the leading pixels are dropped, busy stays 0 until sof, and output matches scenario 1.
4. sof asserted at pixel (2,1) of frame A, then a full frame B -> no window from A after the abort; B yields 4 correct windows.
5. rst pulsed mid-RUN (asynchronous, between edges) -> out_valid/win/busy go to 0 immediately. The next full frame produces correct output.
6. WIN3_FRAME_FLAGS_EN defined, IMG_W=5, IMG_H=4 -> 6 windows. out_sof is set only on window 1; out_eol is set on windows 3 and 6.

Source files
------------

// File: rtl/img_pkg.sv
// Shared definitions for the gray-scale image pipeline: default pixel width,
// bit positions of the nine window taps, and the window generator FSM states.
package img_pkg;

  // Default gray pixel width.
  localparam int PIX_DW   = 8;
  localparam int WIN_TAPS = 9;

  // Window tap bit positions at the default pixel width.
  // s0..s2 = top row, s3..s5 = middle row (s4 centre), s6..s8 = bottom row.
  localparam int S0_LSB = 0 * PIX_DW;
  localparam int S1_LSB = 1 * PIX_DW;
  localparam int S2_LSB = 2 * PIX_DW;
  localparam int S3_LSB = 3 * PIX_DW;
  localparam int S4_LSB = 4 * PIX_DW;
  localparam int S5_LSB = 5 * PIX_DW;
  localparam int S6_LSB = 6 * PIX_DW;
  localparam int S7_LSB = 7 * PIX_DW;
  localparam int S8_LSB = 8 * PIX_DW;

  // Frame state: waiting for sof, filling the two line buffers, emitting windows.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } win_state_e;

  // Bit position of window tap 'tap' for an arbitrary pixel width.
  function automatic int tap_lsb(input int tap, input int dw);
    return tap * dw;
  endfunction

endpackage

// File: rtl/line_buf_1p.sv
// Single-port line buffer: one image line of pixels, combinational read at
// addr, synchronous write on we. Contents are deliberately not reset; the
// window generator's row/column gating keeps stale data out of valid windows.
module line_buf_1p #(
  parameter int DEPTH = 640,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Read is combinational so the old value is visible in the same cycle as
  // the write (read-before-write from the caller's point of view).
  assign rdata = mem[addr];

  // Store the new pixel for this column.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator. Accepts one gray pixel per valid
// cycle in raster order, keeps the two previous lines in line buffers and
// emits a registered 3x3 window one clock after each pixel whose window
// lies fully inside the frame (row >= 2 and col >= 2 of the newest pixel).
// Optional: define WIN3_FRAME_FLAGS_EN to add out_sof / out_eol outputs.
module window_3x3_gen
  import img_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = PIX_DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DW-1:0]     in_data,
  output logic              out_valid,
  output logic [9*DW-1:0]   win,
  output logic              busy
`ifdef WIN3_FRAME_FLAGS_EN
  ,
  output logic              out_sof,
  output logic              out_eol
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  win_state_e    state_reg, state_next;
  logic [CW-1:0] col_reg, col_next;
  logic [RW-1:0] row_reg, row_next;

  logic          start;
  logic          accept;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic [RW-1:0] row_inc;
  logic          win_fire;

  logic [DW-1:0] lb0_rdata;
  logic [DW-1:0] lb1_rdata;
  logic [DW-1:0] new_col [3];

  logic          out_valid_reg;

  // An sof pixel always starts a frame (also aborting a frame in progress);
  // otherwise pixels are only taken while a frame is active.
  assign start   = in_valid && in_sof;
  assign accept  = in_valid && (start || (state_reg != IDLE));

  // Position of the pixel on the input this cycle. An sof pixel is (0,0)
  // regardless of where the counters stood, so all gating uses these.
  assign cur_col = start ? '0 : col_reg;
  assign cur_row = start ? '0 : row_reg;
  assign row_inc = cur_row + RW'(1);

  // A window is complete once the newest pixel is at least two rows and two
  // columns in; this also keeps the column wrap and aborted frames clean.
  assign win_fire = accept && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);

  assign busy = (state_reg != IDLE);

  // Next-state and counter logic for raster position and frame phase.
  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    if (accept) begin
      if (cur_col == COL_LAST) begin
        col_next = '0;
        if (cur_row == ROW_LAST) begin
          row_next   = '0;
          state_next = IDLE;
        end else begin
          row_next   = row_inc;
          state_next = (row_inc >= ROW_TWO) ? RUN : FILL;
        end
      end else begin
        col_next   = cur_col + CW'(1);
        row_next   = cur_row;
        state_next = (cur_row >= ROW_TWO) ? RUN : FILL;
      end
    end
  end

  // Frame state and raster counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      col_reg   <= '0;
      row_reg   <= '0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
    end
  end

  // LB0 holds the previous line, LB1 the line before it. On every accepted
  // pixel the column ripples down: LB1 takes LB0's old value, LB0 the input.
  line_buf_1p #(
    .DEPTH (IMG_W),
    .DW    (DW),
    .AW    (CW)
  ) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata (in_data),
    .rdata (lb0_rdata)
  );

  line_buf_1p #(
    .DEPTH (IMG_W),
    .DW    (DW),
    .AW    (CW)
  ) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata (lb0_rdata),
    .rdata (lb1_rdata)
  );

  // Incoming right-hand column of the window: top, middle, bottom.
  assign new_col[0] = lb1_rdata;
  assign new_col[1] = lb0_rdata;
  assign new_col[2] = in_data;

  // One shift register per window row; each accepted pixel moves the row
  // left by one column and loads the new right-hand pixel.
  for (genvar gi = 0; gi < 3; gi++) begin : gen_row
    logic [DW-1:0] taps [3];

    // Shift this window row on every accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        taps[0] <= '0;
        taps[1] <= '0;
        taps[2] <= '0;
      end else if (accept) begin
        taps[0] <= taps[1];
        taps[1] <= taps[2];
        taps[2] <= new_col[gi];
      end
    end

    assign win[tap_lsb(3*gi + 0, DW) +: DW] = taps[0];
    assign win[tap_lsb(3*gi + 1, DW) +: DW] = taps[1];
    assign win[tap_lsb(3*gi + 2, DW) +: DW] = taps[2];
  end

  // Window qualifier: one-cycle pulse following each completing pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= win_fire;
    end
  end

  assign out_valid = out_valid_reg;

`ifdef WIN3_FRAME_FLAGS_EN
  logic out_sof_reg;
  logic out_eol_reg;

  // Frame markers travel with the window: first window of the frame has its
  // bottom-right pixel at (2,2); a row's last window ends at the last column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sof_reg <= 1'b0;
      out_eol_reg <= 1'b0;
    end else begin
      out_sof_reg <= win_fire && (cur_row == ROW_TWO) && (cur_col == COL_TWO);
      out_eol_reg <= win_fire && (cur_col == COL_LAST);
    end
  end

  assign out_sof = out_sof_reg;
  assign out_eol = out_eol_reg;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 4x4 frame (pixel = 16*r + c).
// Inputs change on the falling edge; outputs are sampled on the next falling
// edge, i.e. one rising edge after the pixel was presented.
// With WIN3_FRAME_FLAGS_EN defined a second 5x4 instance checks the flags.
module tb_window_3x3_gen;
  import img_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic [71:0] win;
  logic        busy;
`ifdef WIN3_FRAME_FLAGS_EN
  logic        out_sof;
  logic        out_eol;
  logic        v5 = 1'b0;
  logic        sof5 = 1'b0;
  logic [7:0]  d5 = 8'h00;
  logic        ov5;
  logic [71:0] win5;
  logic        busy5;
  logic        osof5;
  logic        oeol5;
`endif

  window_3x3_gen #(.IMG_W(4), .IMG_H(4), .DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .win       (win),
    .busy      (busy)
`ifdef WIN3_FRAME_FLAGS_EN
    ,
    .out_sof   (out_sof),
    .out_eol   (out_eol)
`endif
  );

`ifdef WIN3_FRAME_FLAGS_EN
  window_3x3_gen #(.IMG_W(5), .IMG_H(4), .DW(8)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v5),
    .in_sof    (sof5),
    .in_data   (d5),
    .out_valid (ov5),
    .win       (win5),
    .busy      (busy5),
    .out_sof   (osof5),
    .out_eol   (oeol5)
  );
`endif

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int nwin     = 0;

  // Expected windows of the 4x4 frame, keyed by the pixel that completes them.
  typedef struct {
    int          r;
    int          c;
    logic [71:0] win;
  } vec_t;
  vec_t tbl [4];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One cycle: present inputs, let one rising edge pass, check the outputs.
  task automatic pix(input logic v, input logic s, input logic [7:0] d,
                     input int idx, input logic esof, input logic eeol);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(negedge clk);
    chk1("out_valid", out_valid, idx >= 0);
    if (idx >= 0) begin
      chkw($sformatf("win_r%0d_c%0d", tbl[idx].r, tbl[idx].c), win, tbl[idx].win);
      nwin++;
    end
`ifdef WIN3_FRAME_FLAGS_EN
    chk1("out_sof", out_sof, esof);
    chk1("out_eol", out_eol, eeol);
`else
    if (esof || eeol) begin end
`endif
    $display("cyc v=%b sof=%b d=%h -> out_valid=%b win=%h busy=%b",
             v, s, d, out_valid, win, busy);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Send the first npix pixels of a 4x4 frame with 0..max_gap idle cycles
  // before each pixel.
  task automatic frame(input int npix, input int max_gap, input logic [7:0] base);
    int n = 0;
    nwin = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (n < npix) begin
          int g;
          int idx;
          g = int'($urandom_range(max_gap, 0));
          repeat (g) pix(1'b0, 1'b0, 8'h00, -1, 1'b0, 1'b0);
          idx = -1;
          for (int i = 0; i < 4; i++) begin
            if (tbl[i].r == r && tbl[i].c == c) idx = i;
          end
          pix(1'b1, (r == 0 && c == 0), 8'(base + 16*r + c), idx,
              (r == 2 && c == 2), (idx >= 0 && c == 3));
          if (n == 0) chk1("busy_after_sof", busy, 1'b1);
          n++;
        end
      end
    end
    if (npix == 16) begin
      chk1("busy_after_last", busy, 1'b0);
      chki("window_count", nwin, 4);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2, 2, 72'h22_21_20_12_11_10_02_01_00};
    tbl[1] = '{2, 3, 72'h23_22_21_13_12_11_03_02_01};
    tbl[2] = '{3, 2, 72'h32_31_30_22_21_20_12_11_10};
    tbl[3] = '{3, 3, 72'h33_32_31_23_22_21_13_12_11};

    // Reset state
    #12;
    chk1("rst_out_valid", out_valid, 1'b0);
    chkw("rst_win", win, 72'h0);
    chk1("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: continuous frame
    frame(16, 0, 8'h00);
    chkw("first_s4", 72'(tbl[0].win[S4_LSB +: 8]), 72'h11);
    repeat (2) pix(1'b0, 1'b0, 8'h00, -1, 1'b0, 1'b0);

    // 2: same frame with random gaps
    frame(16, 3, 8'h00);

    // 3: pixels without sof are dropped
    for (int i = 0; i < 5; i++) begin
      pix(1'b1, 1'b0, 8'(8'hA0 + i), -1, 1'b0, 1'b0);
      chk1("busy_no_sof", busy, 1'b0);
    end
    frame(16, 0, 8'h00);

    // 4: frame A aborted by sof at its pixel (2,1), then full frame B
    frame(9, 0, 8'h80);
    frame(16, 0, 8'h00);

    // 5: asynchronous reset mid-RUN, after the window of pixel (2,3)
    frame(12, 0, 8'h00);
    chk1("pre_rst_valid", out_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk1("arst_out_valid", out_valid, 1'b0);
    chkw("arst_win", win, 72'h0);
    chk1("arst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frame(16, 0, 8'h00);

`ifdef WIN3_FRAME_FLAGS_EN
    // 6: frame flags on a 5x4 frame
    begin
      int k = 0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 5; c++) begin
          logic ev;
          v5   = 1'b1;
          sof5 = (r == 0 && c == 0);
          d5   = 8'(16*r + c);
          @(negedge clk);
          ev = (r >= 2 && c >= 2);
          if (ev) k++;
          chk1("f5_valid", ov5, ev);
          chk1("f5_sof", osof5, ev && k == 1);
          chk1("f5_eol", oeol5, ev && (k == 3 || k == 6));
          if (ev) begin
            chkw("f5_s8", 72'(win5[S8_LSB +: 8]), 72'(16*r + c));
            chkw("f5_s0", 72'(win5[S0_LSB +: 8]), 72'(16*(r-2) + c - 2));
          end
          $display("f5 r=%0d c=%0d -> out_valid=%b sof=%b eol=%b win=%h",
                   r, c, ov5, osof5, oeol5, win5);
          v5   = 1'b0;
          sof5 = 1'b0;
        end
      end
      chki("f5_count", k, 6);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
